// File: rtl/weight_fifo.sv
// weight_fifo
//   Staging buffer between weight memory and the systolic array's weight-load
//   path. Rows arrive through a valid/ready handshake. One full tile of
//   TILE_ROWS rows is released per request from the control unit, one row per
//   cycle whenever data is available.
//
// Ports
//   clk_i                rising-edge clock
//   rst_i                synchronous active-low reset
//   wr_valid_i/wr_data_i memory side row offer
//   wr_ready_o           buffer can accept a row (from registered count only)
//   load_weights_i       level request for the next tile
//   weight_fifo_valid_o  registered: weight_data_o holds a popped row
//   weight_data_o        registered popped row
//   tile_done_o          registered one-cycle pulse with the last row of a tile
//   fifo_full_o          occupancy == DEPTH
//   tile_avail_o         occupancy >= TILE_ROWS
//   empty_o              occupancy == 0
module weight_fifo #(
  parameter int DATA_W    = 256,
  parameter int TILE_ROWS = 32,
  parameter int DEPTH     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              load_weights_i,
  output logic              weight_fifo_valid_o,
  output logic [DATA_W-1:0] weight_data_o,
  output logic              tile_done_o,
  output logic              fifo_full_o,
  output logic              tile_avail_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TILE_ROWS);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   TILE_COUNT = (AW+1)'(TILE_ROWS);
  localparam logic [TW-1:0] LAST_ROW   = TW'(TILE_ROWS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [TW-1:0]     row_cntr;
  state_t            state;
  logic              push;
  logic              pop;

  // Status is decoded from the registered count, so wr_ready_o has no
  // combinational path from any input.
  assign wr_ready_o   = (count != FULL_COUNT);
  assign fifo_full_o  = (count == FULL_COUNT);
  assign tile_avail_o = (count >= TILE_COUNT);
  assign empty_o      = (count == '0);

  assign push = wr_valid_i & wr_ready_o;
  // Reads come only from stored rows; a row pushed this cycle is not
  // visible to the read side until the next cycle.
  assign pop  = (state == STREAM) && (count != '0);

  // Row storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointers, occupancy, the tile read state machine and registered outputs.
  // A tile, once started, always runs to its last row; HOLD then waits for
  // the request to drop so each tile needs a fresh request level.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      row_cntr            <= '0;
      state               <= IDLE;
      weight_fifo_valid_o <= 1'b0;
      weight_data_o       <= '0;
      tile_done_o         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      weight_fifo_valid_o <= pop;
      tile_done_o         <= 1'b0;
      if (pop) begin
        weight_data_o <= mem[rd_ptr];
      end

      case (state)
        IDLE: begin
          if (load_weights_i) begin
            state    <= STREAM;
            row_cntr <= '0;
          end
        end
        STREAM: begin
          if (pop) begin
            row_cntr <= row_cntr + TW'(1);
            if (row_cntr == LAST_ROW) begin
              tile_done_o <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!load_weights_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_fifo.md
# weight_fifo

Tile-aware weight staging FIFO between weight memory and the systolic array's weight-load path. It accepts weight rows from the memory side through a valid/ready handshake. It releases exactly one 32-row tile per `load_weights` request from the control unit, driving `weight_fifo_valid_output` once per row so the control unit's load counter advances. It also reports fullness and tile availability back to the control unit.

## Interface
- `DATA_W`, 256: width of one weight row (32 lanes × 8 bit).
- `TILE_ROWS`, 32: rows per weight tile; must be a power of two.
- `DEPTH`, 64: row capacity; must be a power of two and a multiple of `TILE_ROWS`.

Ports (reset is synchronous and active-low):
- `clk_i` input 1: clock; all state updates on its rising edge.
- `rst_i` input 1: synchronous, active-low reset.
- `wr_valid_i` input 1: memory side presents a row.
- `wr_data_i` input DATA_W: row data.
- `wr_ready_o` output 1: FIFO can accept a row this cycle.
- `load_weights_i` input 1: control unit requests the next tile (level).
- `weight_fifo_valid_o` output 1: `weight_data_o` holds a valid row this cycle.
- `weight_data_o` output DATA_W: popped row.
- `tile_done_o` output 1: one-cycle pulse with the last row of a tile.
- `fifo_full_o` output 1: occupancy == `DEPTH`.
- `tile_avail_o` output 1: occupancy ≥ `TILE_ROWS`.
- `empty_o` output 1: occupancy == 0.

## Operation
**Storage**
- Circular buffer of `DEPTH` rows.
- `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap naturally.
- `count` is log2(DEPTH)+1 bits.

**Push**
- `push = wr_valid_i & wr_ready_o`.
- `wr_ready_o = (count != DEPTH)`, registered-equivalent: it depends only on registered count, so there is no combinational path from any input.

**Read state machine**
- States: `IDLE`, `STREAM`, `HOLD`.
- `IDLE`: when `load_weights_i` = 1, go to `STREAM` and clear `row_cntr`.
- `STREAM`: `pop = (count != 0)`.
  - Each pop increments `row_cntr` (log2(TILE_ROWS) bits).
  - On the pop with `row_cntr == TILE_ROWS-1`: set `tile_done_o`, then go to `HOLD`.
  - If the FIFO is empty, stall in `STREAM` without popping and without a valid output.
  - Deassertion of `load_weights_i` in `STREAM` does not abort: the tile always completes.
- `HOLD`: no pops. Return to `IDLE` when `load_weights_i` = 0.
  - This absorbs the control unit's registered request, which stays high for at least one cycle after the 32nd row.
  - A new tile requires a fresh rising level on `load_weights_i`.

**Simultaneous push and pop**
- `count` is unchanged; both pointers advance.
- Push on a full FIFO is impossible because `wr_ready_o` = 0.
- Pop on an empty FIFO is suppressed.
- Push into an empty FIFO while in `STREAM`: the row is popped next cycle at the earliest. There is no write-to-read bypass.

**Status**
- `fifo_full_o`, `tile_avail_o` and `empty_o` are decoded from registered `count`.
- They reflect the count after the previous edge.

## Timing
**Reset values** (while `rst_i` = 0 at a clock edge):
- `wr_ptr`, `rd_ptr`, `count` and `row_cntr` = 0; state = `IDLE`.
- `weight_fifo_valid_o` = 0, `weight_data_o` = 0, `tile_done_o` = 0.
- `fifo_full_o` = 0, `tile_avail_o` = 0, `empty_o` = 1, `wr_ready_o` = 1.

**Reset mid-operation**
- Resetting during a tile discards all contents and partial tile progress.
- There is no output pulse during or after reset.

**Latency**
- `load_weights_i` rises at edge N (sampled) → state is `STREAM` after N.
- First pop at edge N+1 → `weight_fifo_valid_o` and row data registered, visible after N+1. Request-to-first-valid is 2 cycles.

**Throughput**
- With the FIFO non-empty, one row per cycle: `TILE_ROWS` consecutive valid cycles per tile.
- `tile_done_o` coincides with the final valid.

**Write side**
- A write accepted at edge N raises `count` after N; `tile_avail_o` can rise in the cycle after N.
- Full throughput of one row per cycle until full.

## Test plan
1. Reset then fill: push 64 rows (row i = i).
   - `wr_ready_o` = 1 through the 64th accept, then 0.
   - `fifo_full_o` = 1 and `tile_avail_o` = 1 after the last push.
2. Single tile: with 64 rows stored, hold `load_weights_i` high 35 cycles.
   - Exactly 32 valids, data 0..31 in order; `tile_done_o` with row 31.
   - `count` = 32 afterwards; no pops while in `HOLD`.
3. Re-arm: drop `load_weights_i` for 1 cycle, then raise it.
   - Rows 32..63 stream out; `empty_o` = 1 at the end; the pointers have wrapped to 0.
4. Starved stream: request a tile with 5 rows stored, then push the remaining 27 rows at 1 row per 3 cycles.
   - Valids occur only when data is present; all 32 rows arrive in order; `tile_done_o` on the 32nd.
5. Concurrent push/pop: FIFO at 63 rows, pushing and streaming every cycle.
   - `count` holds at 63; `wr_ready_o` stays 1; order is preserved across the wrap.
6. Reset mid-tile: assert `rst_i` = 0 after 10 rows of a tile.
   - All outputs take their reset values next cycle.
   - A subsequent request with an empty FIFO yields no valids.
